// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake bundle for serial_subtractor: request operands in, held result out.
interface serial_subtractor_if #(
   parameter int unsigned WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Bi;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] D;
   logic             Bo;

   modport master (output start, A, B, Bi, input busy, done, D, Bo);
   modport slave  (input start, A, B, Bi, output busy, done, D, Bo);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - Bi subtractor: one full-subtractor cell reused over WIDTH cycles, LSB first.
module serial_subtractor #(
   parameter int unsigned WIDTH = 4
) (
   input logic                clk,
   input logic                reset,
   serial_subtractor_if.slave bus
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] d_sh_q, d_sh_d;
   logic [WIDTH-1:0] d_out_q, d_out_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d;
   logic             bo_q, bo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             a0, b0, dbit, nbr;
   logic [WIDTH-1:0] d_shifted;

   always_comb begin
      a0   = a_sh_q[0];
      b0   = b_sh_q[0];
      dbit = a0 ^ b0 ^ br_q;
      nbr  = (~a0 & b0) | (~a0 & br_q) | (b0 & br_q);
      // Shift then overwrite the MSB so the same expression holds for WIDTH = 1.
      d_shifted            = d_sh_q >> 1;
      d_shifted[WIDTH-1]   = dbit;

      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      d_sh_d  = d_sh_q;
      d_out_d = d_out_q;
      cnt_d   = cnt_q;
      br_d    = br_q;
      bo_d    = bo_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_sh_d  = bus.A;
               b_sh_d  = bus.B;
               br_d    = bus.Bi;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            d_sh_d = d_shifted;
            br_d   = nbr;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               d_out_d = d_shifted;
               bo_d    = nbr;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         d_sh_q  <= '0;
         d_out_q <= '0;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         bo_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         d_sh_q  <= d_sh_d;
         d_out_q <= d_out_d;
         cnt_q   <= cnt_d;
         br_q    <= br_d;
         bo_q    <= bo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.D    = d_out_q;
   assign bus.Bo   = bo_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, table-driven bench for serial_subtractor (WIDTH = 4) plus handshake corner sequences.
module tb_serial_subtractor;
   localparam int unsigned WIDTH = 4;

   logic clk = 1'b0;
   logic reset;

   serial_subtractor_if #(.WIDTH(WIDTH)) sif ();

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sif)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       bi;
      logic [3:0] exp_d;
      logic       exp_bo;
   } vec_t;

   vec_t vecs[9];
   int   total  = 0;
   int   passed = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Issue one request, follow it to done, and check latency, result and pulse width.
   task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bi,
                         input logic [3:0] exp_d, input logic exp_bo);
      int lat;
      int busy_ok;
      sif.start = 1'b1; sif.A = a; sif.B = b; sif.Bi = bi;
      step();
      sif.start = 1'b0;
      lat = 1;
      busy_ok = 1;
      while (sif.done !== 1'b1 && lat < 20) begin
         if (sif.busy !== 1'b1) busy_ok = 0;
         step();
         lat++;
      end
      check("latency", lat, WIDTH + 1);
      check("busy_during_run", busy_ok, 1);
      check("result_D", sif.D, exp_d);
      check("result_Bo", sif.Bo, exp_bo);
      check("busy_at_done", sif.busy, 0);
      step();
      check("done_one_cycle", sif.done, 0);
      check("D_held", sif.D, exp_d);
   endtask

   initial begin
      int seen;
      vecs[0] = '{4'h3, 4'h1, 1'b0, 4'h2, 1'b0};
      vecs[1] = '{4'h1, 4'h2, 1'b0, 4'hF, 1'b1};
      vecs[2] = '{4'h0, 4'h0, 1'b1, 4'hF, 1'b1};
      vecs[3] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
      vecs[4] = '{4'hF, 4'h0, 1'b0, 4'hF, 1'b0};
      vecs[5] = '{4'h5, 4'h3, 1'b0, 4'h2, 1'b0};
      vecs[6] = '{4'h8, 4'h1, 1'b0, 4'h7, 1'b0};
      vecs[7] = '{4'h9, 4'h4, 1'b1, 4'h4, 1'b0};
      vecs[8] = '{4'h0, 4'hF, 1'b0, 4'h1, 1'b1};

      reset = 1'b1; sif.start = 1'b0; sif.A = '0; sif.B = '0; sif.Bi = 1'b0;
      step(); step();
      check("reset_busy", sif.busy, 0);
      check("reset_done", sif.done, 0);
      check("reset_D", sif.D, 0);
      check("reset_Bo", sif.Bo, 0);
      reset = 1'b0;
      step();

      foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].bi, vecs[i].exp_d, vecs[i].exp_bo);

      // Busy rejection: second request at t+2 must be ignored.
      sif.start = 1'b1; sif.A = 4'h5; sif.B = 4'h3; sif.Bi = 1'b0;
      step();
      sif.start = 1'b0;
      step();
      sif.start = 1'b1; sif.A = 4'hF; sif.B = 4'h0;
      step();
      sif.start = 1'b0;
      check("reject_busy", sif.busy, 1);
      step();
      check("reject_no_early_done", sif.done, 0);
      step();
      check("reject_done", sif.done, 1);
      check("reject_D", sif.D, 4'h2);
      check("reject_Bo", sif.Bo, 0);
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         if (sif.done !== 1'b0 || sif.busy !== 1'b0 || sif.D !== 4'h2) seen++;
      end
      check("reject_idle_hold", seen, 0);

      // Back-to-back: restart in the done cycle.
      sif.start = 1'b1; sif.A = 4'h3; sif.B = 4'h1; sif.Bi = 1'b0;
      step();
      sif.start = 1'b0;
      for (int k = 0; k < 3; k++) step();
      step();
      check("b2b_first_done", sif.done, 1);
      check("b2b_first_D", sif.D, 4'h2);
      sif.start = 1'b1; sif.A = 4'h8; sif.B = 4'h1;
      step();
      sif.start = 1'b0;
      seen = 0;
      for (int k = 0; k < 4; k++) begin
         if (sif.done !== 1'b0) seen++;
         step();
      end
      check("b2b_no_extra_done", seen, 0);
      check("b2b_second_done", sif.done, 1);
      check("b2b_second_D", sif.D, 4'h7);
      check("b2b_second_Bo", sif.Bo, 0);
      step();

      // Reset mid-RUN, with a start presented alongside reset.
      sif.start = 1'b1; sif.A = 4'h6; sif.B = 4'h2;
      step();
      sif.start = 1'b0;
      reset = 1'b1;
      sif.start = 1'b1; sif.A = 4'hF; sif.B = 4'h0;
      step();
      reset = 1'b0;
      sif.start = 1'b0;
      check("rst_busy", sif.busy, 0);
      check("rst_D", sif.D, 0);
      check("rst_Bo", sif.Bo, 0);
      seen = 0;
      for (int k = 0; k < 7; k++) begin
         if (sif.done !== 1'b0 || sif.busy !== 1'b0) seen++;
         step();
      end
      check("rst_no_done", seen, 0);
      run_op(4'h6, 4'h2, 1'b0, 4'h4, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got hang expected finish");
      $fatal(1);
   end
endmodule
